// File: rtl/rsa_core_scheduler.sv
// Round-robin scheduler sharing one Rsa256Core between N_REQ requesters, one job in flight.
// Optional busy watchdog enabled by defining RSA_SCHED_TIMEOUT_EN.
module rsa_core_scheduler #(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned W              = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic               avm_clk,
    input  logic               avm_rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_d,
    input  logic [N_REQ*W-1:0] req_n,
    output logic [N_REQ-1:0]   resp_valid,
    input  logic [N_REQ-1:0]   resp_ready,
    output logic [W-1:0]       resp_data,
    output logic               resp_err,
    output logic               core_rst,
    output logic               core_start,
    output logic [W-1:0]       core_a,
    output logic [W-1:0]       core_d,
    output logic [W-1:0]       core_n,
    input  logic [W-1:0]       core_result,
    input  logic               core_finished
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW:0] NREQ_W = (PW+1)'(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("rsa_core_scheduler: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RESP} state_t;

    state_t              r_state, w_next;
    logic [PW-1:0]       r_rr_ptr, r_owner;
    logic [PW-1:0]       w_winner, w_off, w_ptr_next;
    logic [PW:0]         w_sum;
    logic                w_found, w_accept, w_resp_done, w_timeout;
    logic [2*N_REQ-1:0]  w_dbl, w_rot;
    logic [W-1:0]        r_a, r_d, r_n, r_resp_data;
    logic [W-1:0]        w_sel_a, w_sel_d, w_sel_n;

    // Rotate the request vector so bit 0 is rr_ptr; lowest set bit is the winner.
    always_comb begin
        w_dbl   = {req_valid, req_valid};
        w_rot   = w_dbl >> r_rr_ptr;
        w_found = 1'b0;
        w_off   = '0;
        for (int unsigned k = N_REQ; k > 0; k--) begin
            if (w_rot[k-1]) begin
                w_found = 1'b1;
                w_off   = PW'(k-1);
            end
        end
        w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
        w_winner = (w_sum >= NREQ_W) ? PW'(w_sum - NREQ_W) : PW'(w_sum);
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_d = '0;
        w_sel_n = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_winner == PW'(i)) begin
                w_sel_a = req_a[i*W +: W];
                w_sel_d = req_d[i*W +: W];
                w_sel_n = req_n[i*W +: W];
            end
        end
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (r_state == S_IDLE && w_found)
            req_ready[w_winner] = 1'b1;
        if (r_state == S_RESP)
            resp_valid[r_owner] = 1'b1;
    end

    assign w_accept    = (r_state == S_IDLE) && w_found;
    assign w_resp_done = (r_state == S_RESP) && resp_ready[r_owner];
    assign w_ptr_next  = (r_owner == PW'(N_REQ-1)) ? '0 : r_owner + 1'b1;

    assign core_start = (r_state == S_START);
    assign core_a     = r_a;
    assign core_d     = r_d;
    assign core_n     = r_n;
    assign resp_data  = r_resp_data;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_START;
            S_START: w_next = S_BUSY;
            S_BUSY:  if (core_finished || w_timeout) w_next = S_RESP;
            S_RESP:  if (resp_ready[r_owner]) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_a         <= '0;
            r_d         <= '0;
            r_n         <= '0;
            r_resp_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a     <= w_sel_a;
                r_d     <= w_sel_d;
                r_n     <= w_sel_n;
                r_owner <= w_winner;
            end
            if (r_state == S_BUSY && core_finished)
                r_resp_data <= core_result;
            else if (w_timeout)
                r_resp_data <= '0;
            if (w_resp_done)
                r_rr_ptr <= w_ptr_next;
        end
    end

`ifdef RSA_SCHED_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_core_rst, r_resp_err;

    // Counter holds the number of completed busy cycles; trips on the TIMEOUT_CYCLES-th one.
    assign w_timeout = (r_state == S_BUSY) && !core_finished &&
                       (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign core_rst  = r_core_rst;
    assign resp_err  = r_resp_err;

    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            r_cnt      <= '0;
            r_core_rst <= 1'b0;
            r_resp_err <= 1'b0;
        end else begin
            r_core_rst <= w_timeout;
            if (r_state == S_START)
                r_cnt <= '0;
            else if (r_state == S_BUSY)
                r_cnt <= r_cnt + 1'b1;
            if (w_timeout)
                r_resp_err <= 1'b1;
            else if (w_resp_done)
                r_resp_err <= 1'b0;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign core_rst  = 1'b0;
    assign resp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_core_scheduler.sv
// Randomised bench for rsa_core_scheduler with a behavioural core and round-robin reference model.
// Watchdog expectations follow RSA_SCHED_TIMEOUT_EN when it is defined.
module tb_rsa_core_scheduler;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int TO = 16;

    logic             avm_clk = 1'b0;
    logic             avm_rst_n;
    logic [N-1:0]     req_valid, req_ready, resp_valid, resp_ready;
    logic [N*W-1:0]   req_a, req_d, req_n;
    logic [W-1:0]     resp_data, core_a, core_d, core_n, core_result;
    logic             resp_err, core_rst, core_start, core_finished;

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;
    int m_ptr    = 0;
    logic [W-1:0] op_a [N];
    logic [W-1:0] op_d [N];
    logic [W-1:0] op_n [N];

    rsa_core_scheduler #(.N_REQ(N), .W(W), .TIMEOUT_CYCLES(TO)) dut (
        .avm_clk(avm_clk), .avm_rst_n(avm_rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_d(req_d), .req_n(req_n),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .core_rst(core_rst), .core_start(core_start),
        .core_a(core_a), .core_d(core_d), .core_n(core_n),
        .core_result(core_result), .core_finished(core_finished)
    );

    always #5 avm_clk = ~avm_clk;

    always @(posedge avm_clk) if (core_start === 1'b1) n_starts <= n_starts + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge avm_clk);
        #1;
    endtask

    function automatic logic [W-1:0] modexp(input logic [W-1:0] a, input logic [W-1:0] d,
                                            input logic [W-1:0] n);
        longint unsigned r;
        if (n == 0) return '0;
        r = 64'(1) % 64'(n);
        for (longint unsigned i = 0; i < 64'(d); i++) r = (r * 64'(a)) % 64'(n);
        return W'(r);
    endfunction

    // Reference arbiter: first valid requester scanning from the pointer, wrapping.
    function automatic int arb(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] r;
        r = '0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_d[i*W +: W] = op_d[i];
            req_n[i*W +: W] = op_n[i];
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] d,
                          input logic [W-1:0] n);
        op_a[i] = a;
        op_d[i] = d;
        op_n[i] = n;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            op_n[i] = W'($urandom_range(2, 1000));
            op_a[i] = W'($urandom_range(0, 32'(op_n[i]) - 1));
            op_d[i] = W'($urandom_range(0, 40));
        end
    endtask

    task automatic do_reset();
        req_valid = '0; resp_ready = '0; core_finished = 1'b0; core_result = '0;
        avm_rst_n = 1'b0;
        tick(); tick();
        avm_rst_n = 1'b1;
        m_ptr = 0;
    endtask

    task automatic do_job(input logic [N-1:0] valid, input int lat, input int rdly);
        int w, s0;
        logic [W-1:0] ea, ed, en, er;
        req_valid = '0; core_result = W'($urandom); core_finished = 1'b1;
        tick();
        core_finished = 1'b0;
        check("idle_finished_ignored", 64'(resp_valid), 0);
        pack();
        req_valid = valid;
        #1;
        w = arb(valid, m_ptr);
        check("req_ready_grant", 64'(req_ready), 64'(onehot(w)));
        ea = op_a[w]; ed = op_d[w]; en = op_n[w];
        er = modexp(ea, ed, en);
        s0 = n_starts;
        tick();
        check("core_start_pulse", 64'(core_start), 1);
        check("core_a", 64'(core_a), 64'(ea));
        check("core_d", 64'(core_d), 64'(ed));
        check("core_n", 64'(core_n), 64'(en));
        check("ready_in_start", 64'(req_ready), 0);
        req_valid = N'($urandom);
        rand_ops();
        pack();
        tick();
        check("core_start_single", 64'(core_start), 0);
        for (int i = 1; i < lat; i++) begin
            check("busy_no_resp", 64'(resp_valid), 0);
            check("busy_no_ready", 64'(req_ready), 0);
            tick();
        end
        core_result = modexp(core_a, core_d, core_n);
        core_finished = 1'b1;
        tick();
        core_finished = 1'b0;
        check("resp_valid", 64'(resp_valid), 64'(onehot(w)));
        check("resp_data", 64'(resp_data), 64'(er));
        check("resp_err", 64'(resp_err), 0);
        check("core_a_stable", 64'(core_a), 64'(ea));
        for (int r = 0; r < rdly; r++) begin
            resp_ready = ~onehot(w);
            tick();
            check("resp_valid_hold", 64'(resp_valid), 64'(onehot(w)));
            check("resp_data_hold", 64'(resp_data), 64'(er));
            check("ready_in_resp", 64'(req_ready), 0);
        end
        resp_ready = onehot(w);
        tick();
        resp_ready = '0;
        req_valid = '0;
        check("resp_done", 64'(resp_valid), 0);
        check("start_count", 64'(n_starts - s0), 1);
        m_ptr = (w + 1) % N;
    endtask

    initial begin
        int w;
        req_a = '0; req_d = '0; req_n = '0;
        do_reset();

        check("rst_req_ready", 64'(req_ready), 0);
        check("rst_resp_valid", 64'(resp_valid), 0);
        check("rst_core_start", 64'(core_start), 0);
        check("rst_core_rst", 64'(core_rst), 0);
        check("rst_resp_err", 64'(resp_err), 0);
        check("rst_resp_data", 64'(resp_data), 0);
        check("rst_core_a", 64'(core_a), 0);

        set_op(0, 5, 3, 33);
        do_job(3'b001, 3, 0);

        // Reset while busy: job discarded, pointer back to 0.
        set_op(1, 3, 4, 7);
        pack();
        req_valid = 3'b010;
        tick();
        tick();
        req_valid = '0;
        avm_rst_n = 1'b0;
        tick();
        avm_rst_n = 1'b1;
        m_ptr = 0;
        check("midrst_resp_valid", 64'(resp_valid), 0);
        check("midrst_core_start", 64'(core_start), 0);
        check("midrst_resp_data", 64'(resp_data), 0);
        check("midrst_core_a", 64'(core_a), 0);
        check("midrst_core_rst", 64'(core_rst), 0);
        core_result = 32'h1234; core_finished = 1'b1;
        tick();
        core_finished = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("late_finished_ignored", 64'(resp_valid), 0);
            tick();
        end

        set_op(0, 2, 10, 1000); set_op(1, 7, 2, 10);
        do_job(3'b011, 4, 1);
        set_op(0, 2, 10, 1000); set_op(1, 7, 2, 10);
        do_job(3'b011, 2, 0);

        for (int j = 0; j < 4; j++) begin
            rand_ops();
            do_job(3'b011, $urandom_range(1, 4), 0);
        end

        rand_ops();
        do_job(3'b001, 2, 20);

        for (int j = 0; j < 40; j++) begin
            rand_ops();
            do_job(N'($urandom_range(1, 7)), $urandom_range(1, 6), $urandom_range(0, 4));
        end

        // Core never finishes.
        rand_ops();
        pack();
        req_valid = 3'b111;
        #1;
        w = arb(3'b111, m_ptr);
        tick();
        req_valid = '0;
        tick();
`ifdef RSA_SCHED_TIMEOUT_EN
        for (int i = 0; i < TO - 1; i++) begin
            check("wd_no_resp", 64'(resp_valid), 0);
            check("wd_no_rst", 64'(core_rst), 0);
            tick();
        end
        check("wd_last_busy", 64'(resp_valid), 0);
        tick();
        check("wd_core_rst", 64'(core_rst), 1);
        check("wd_resp_valid", 64'(resp_valid), 64'(onehot(w)));
        check("wd_resp_err", 64'(resp_err), 1);
        check("wd_resp_data", 64'(resp_data), 0);
        tick();
        check("wd_core_rst_pulse", 64'(core_rst), 0);
        check("wd_err_hold", 64'(resp_err), 1);
        resp_ready = onehot(w);
        tick();
        resp_ready = '0;
        check("wd_err_clear", 64'(resp_err), 0);
        check("wd_resp_done", 64'(resp_valid), 0);
`else
        req_valid = 3'b110;
        for (int i = 0; i < 40; i++) begin
            check("hang_no_resp", 64'(resp_valid), 0);
            check("hang_no_rst", 64'(core_rst), 0);
            check("hang_no_ready", 64'(req_ready), 0);
            tick();
        end
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
